// File: rtl/mesh_term_pkg.sv
// Shared types and helpers for the mesh terminal bridge.
//   n_term()  : number of edge terminals of a ROWS x COLUMS mesh
//   dest_id() : destination id held in the top byte of a packet
//   BDCST_ID  : default broadcast destination id
//   rx_state_t: receive capture FSM states
package mesh_term_pkg;

  localparam logic [7:0] BDCST_ID  = 8'hFF;

  // Widest packet dest_id() accepts; callers zero-extend into this width.
  localparam int         PKT_MAX_W = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    POP  = 2'd1,
    GAP  = 2'd2
  } rx_state_t;

  function automatic int n_term(input int rows, input int colums);
    return 2 * rows + 2 * colums;
  endfunction

  // Top 8 bits of a pkt_w-bit packet held in the low bits of pkt.
  function automatic logic [7:0] dest_id(input logic [PKT_MAX_W-1:0] pkt,
                                         input int pkt_w);
    return 8'(pkt >> (pkt_w - 8));
  endfunction

endpackage

// File: rtl/mesh_term_fifo.sv
// Synchronous show-ahead FIFO.
//   i_push/i_data : write i_data at the edge (accepted when not full, or when
//                   full and a pop happens in the same cycle)
//   i_pop         : retire the head; ignored while empty
//   o_head        : current head, forced to 0 while empty
//   o_full/o_empty/o_count : occupancy
module mesh_term_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic                       o_full,
  output logic                       o_empty,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;

  logic w_do_pop;
  logic w_do_push;

  assign o_full    = (r_count == CNT_W'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;

  // A pop frees a slot in the same cycle, so a push into a full FIFO still
  // lands when it is paired with a pop.
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Gating the head keeps the visible output at 0 when empty, which is what
  // lets the storage array go without a reset.
  assign o_head    = o_empty ? '0 : r_mem[r_rd_ptr];

  // NOTE: storage is deliberately not reset; only pointers/count are, and the
  // head gating above hides stale contents.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push)
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      if (w_do_pop)
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/mesh_term_bridge.sv
// Terminal-side bridge between host agents and the mesh edge terminals.
// Per terminal: a TX FIFO offered to the mesh via pndng_i_in/pop, with a
// saturating drop counter, and an RX capture FSM (IDLE->POP->GAP) that pops
// mesh packets into an RX FIFO read by the host, flagging broadcast heads.
//   tx_push/tx_data/tx_full/tx_drop_cnt : host TX side
//   pndng_i_in/data_out_i_in/pop        : TX toward mesh
//   pndng/data_out/popin                : mesh toward RX
//   rx_pop/rx_data/rx_empty/rx_bcst     : host RX side
module mesh_term_bridge
  import mesh_term_pkg::*;
#(
  parameter int         ROWS       = 4,
  parameter int         COLUMS     = 4,
  parameter int         PCKG_SZ    = 32,
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] BDCST      = BDCST_ID,
  parameter int         CNT_W      = 16,
  localparam int        N_TERM     = n_term(ROWS, COLUMS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [N_TERM-1:0]  tx_push,
  input  logic [PCKG_SZ-1:0] tx_data       [N_TERM],
  output logic [N_TERM-1:0]  tx_full,
  output logic [CNT_W-1:0]   tx_drop_cnt   [N_TERM],
  output logic [N_TERM-1:0]  pndng_i_in,
  output logic [PCKG_SZ-1:0] data_out_i_in [N_TERM],
  input  logic [N_TERM-1:0]  pop,
  input  logic [N_TERM-1:0]  pndng,
  input  logic [PCKG_SZ-1:0] data_out      [N_TERM],
  output logic [N_TERM-1:0]  popin,
  input  logic [N_TERM-1:0]  rx_pop,
  output logic [PCKG_SZ-1:0] rx_data       [N_TERM],
  output logic [N_TERM-1:0]  rx_empty,
  output logic [N_TERM-1:0]  rx_bcst
);

  localparam int FCNT_W = $clog2(FIFO_DEPTH + 1);

  for (genvar g = 0; g < N_TERM; g++) begin : g_ch
    logic               w_tx_full;
    logic               w_tx_empty;
    logic [FCNT_W-1:0]  w_tx_count;
    logic               w_tx_drop;
    logic [CNT_W-1:0]   r_drop_cnt;

    logic               w_rx_full;
    logic               w_rx_empty;
    logic [FCNT_W-1:0]  w_rx_count;
    logic [PCKG_SZ-1:0] w_rx_head;
    rx_state_t          r_state;
    rx_state_t          w_next;
    logic               r_popin;
    logic               w_unused;

    // ---------------- TX path ----------------
    mesh_term_fifo #(.WIDTH(PCKG_SZ), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (tx_push[g]),
      .i_data  (tx_data[g]),
      .i_pop   (pop[g]),
      .o_head  (data_out_i_in[g]),
      .o_full  (w_tx_full),
      .o_empty (w_tx_empty),
      .o_count (w_tx_count)
    );

    assign tx_full[g]    = w_tx_full;
    assign pndng_i_in[g] = !w_tx_empty;

    // A push is lost only when full and no pop makes room this cycle.
    assign w_tx_drop = tx_push[g] && w_tx_full && !pop[g];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)
        r_drop_cnt <= '0;
      else if (w_tx_drop && (r_drop_cnt != '1))
        r_drop_cnt <= r_drop_cnt + CNT_W'(1);
    end

    assign tx_drop_cnt[g] = r_drop_cnt;

    // ---------------- RX path ----------------
    // The only writer of the RX FIFO is the POP state, entered solely when
    // the FIFO is not full; host pops during POP can only free space, so the
    // slot checked at IDLE is still free when the write happens.
    always_comb begin
      // NOTE: default first so every path assigns w_next and no latch forms.
      w_next = r_state;
      case (r_state)
        IDLE:    if (pndng[g] && !w_rx_full) w_next = POP;
        POP:     w_next = GAP;
        GAP:     w_next = IDLE;
        default: w_next = IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        r_state <= IDLE;
        r_popin <= 1'b0;
      end else begin
        r_state <= w_next;
        r_popin <= (w_next == POP);
      end
    end

    assign popin[g] = r_popin;

    mesh_term_fifo #(.WIDTH(PCKG_SZ), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk     (clk),
      .reset   (reset),
      .i_push  (r_state == POP),
      .i_data  (data_out[g]),
      .i_pop   (rx_pop[g]),
      .o_head  (w_rx_head),
      .o_full  (w_rx_full),
      .o_empty (w_rx_empty),
      .o_count (w_rx_count)
    );

    assign rx_data[g]  = w_rx_head;
    assign rx_empty[g] = w_rx_empty;
    assign rx_bcst[g]  = !w_rx_empty &&
                         (dest_id(PKT_MAX_W'(w_rx_head), PCKG_SZ) == BDCST);

    // Occupancy counts are not needed at this level.
    assign w_unused = ^{w_tx_count, w_rx_count};
  end

endmodule

// File: tb/tb_mesh_term_bridge.sv
// Self-checking bench for mesh_term_bridge (4x4 mesh, 16 terminals, depth 4).
// A vector table drives TX->pop and mesh->RX loopback per channel; hand
// sequences cover overflow, full push+pop, RX backpressure, popin cadence and
// mid-capture reset. Expected packets go into per-channel queues when driven
// and are compared when the DUT presents them.
module tb_mesh_term_bridge;

  localparam int N  = 16;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  tx_push, tx_full, pndng_i_in, pop, pndng, popin;
  logic [N-1:0]  rx_pop, rx_empty, rx_bcst;
  logic [W-1:0]  tx_data [N];
  logic [W-1:0]  data_out_i_in [N];
  logic [W-1:0]  data_out [N];
  logic [W-1:0]  rx_data [N];
  logic [CW-1:0] tx_drop_cnt [N];

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0] tx_q [N][$];
  logic [W-1:0] rx_q [N][$];

  typedef struct {
    int         ch;
    logic [W-1:0] data;
    logic       exp_bcst;
  } vec_t;

  vec_t vecs [6];

  mesh_term_bridge #(
    .ROWS(4), .COLUMS(4), .PCKG_SZ(W), .FIFO_DEPTH(D), .BDCST(8'hFF), .CNT_W(CW)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .tx_push       (tx_push),
    .tx_data       (tx_data),
    .tx_full       (tx_full),
    .tx_drop_cnt   (tx_drop_cnt),
    .pndng_i_in    (pndng_i_in),
    .data_out_i_in (data_out_i_in),
    .pop           (pop),
    .pndng         (pndng),
    .data_out      (data_out),
    .popin         (popin),
    .rx_pop        (rx_pop),
    .rx_data       (rx_data),
    .rx_empty      (rx_empty),
    .rx_bcst       (rx_bcst)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drain_tx(input int ch);
    logic [W-1:0] exp;
    while (tx_q[ch].size() > 0) begin
      exp = tx_q[ch].pop_front();
      check("tx_pndng", 64'(pndng_i_in[ch]), 64'd1);
      check("tx_head", 64'(data_out_i_in[ch]), 64'(exp));
      pop[ch] = 1'b1;
      step();
      pop[ch] = 1'b0;
    end
    check("tx_idle_after_drain", 64'(pndng_i_in[ch]), 64'd0);
  endtask

  task automatic drain_rx(input int ch);
    logic [W-1:0] exp;
    while (rx_q[ch].size() > 0) begin
      exp = rx_q[ch].pop_front();
      check("rx_not_empty", 64'(rx_empty[ch]), 64'd0);
      check("rx_head", 64'(rx_data[ch]), 64'(exp));
      rx_pop[ch] = 1'b1;
      step();
      rx_pop[ch] = 1'b0;
    end
    check("rx_empty_after_drain", 64'(rx_empty[ch]), 64'd1);
    check("rx_bcst_when_empty", 64'(rx_bcst[ch]), 64'd0);
  endtask

  // Bounded wait for one capture pulse; the captured packet is what the
  // bench is currently driving on data_out.
  task automatic wait_popin(input int ch);
    int k = 0;
    while (!popin[ch] && k < 10) begin
      step();
      k++;
    end
    check("popin_seen", 64'(popin[ch]), 64'd1);
    if (popin[ch]) rx_q[ch].push_back(data_out[ch]);
  endtask

  task automatic rx_window(input int ch, input int cycles,
                           output int pulses, output int bad_gap);
    int last = -1;
    pulses  = 0;
    bad_gap = 0;
    for (int k = 1; k <= cycles; k++) begin
      step();
      if (popin[ch]) begin
        pulses++;
        rx_q[ch].push_back(data_out[ch]);
        if (last >= 0 && (k - last) != 3) bad_gap++;
        last = k;
      end
    end
  endtask

  initial begin
    int           ch;
    int           pulses;
    int           bad;
    logic [W-1:0] acc_d;
    logic [CW-1:0] acc_c;
    logic [W-1:0] exp;

    vecs[0] = '{0,  32'hA1000001, 1'b0};
    vecs[1] = '{5,  32'hFF123456, 1'b1};
    vecs[2] = '{9,  32'hFE00FFFF, 1'b0};
    vecs[3] = '{15, 32'h0BADF00D, 1'b0};
    vecs[4] = '{12, 32'hFFFFFFFF, 1'b1};
    vecs[5] = '{4,  32'h00000000, 1'b0};

    tx_push = '0; pop = '0; pndng = '0; rx_pop = '0;
    for (int i = 0; i < N; i++) begin
      tx_data[i]  = '0;
      data_out[i] = '0;
    end

    // ---- reset state ----
    reset = 1'b1;
    #2;
    reset = 1'b0;
    #1;
    acc_d = '0;
    acc_c = '0;
    for (int i = 0; i < N; i++) begin
      acc_d = acc_d | data_out_i_in[i] | rx_data[i];
      acc_c = acc_c | tx_drop_cnt[i];
    end
    check("rst_tx_full", 64'(tx_full), 64'd0);
    check("rst_pndng_i_in", 64'(pndng_i_in), 64'd0);
    check("rst_popin", 64'(popin), 64'd0);
    check("rst_rx_empty", 64'(rx_empty), 64'hFFFF);
    check("rst_rx_bcst", 64'(rx_bcst), 64'd0);
    check("rst_data_zero", 64'(acc_d), 64'd0);
    check("rst_drop_zero", 64'(acc_c), 64'd0);
    step();
    step();
    reset = 1'b1;
    step();

    // ---- table: TX push/pop, then mesh->RX loopback of the same packet ----
    for (int v = 0; v < 6; v++) begin
      ch = vecs[v].ch;
      tx_push[ch] = 1'b1;
      tx_data[ch] = vecs[v].data;
      tx_q[ch].push_back(vecs[v].data);
      step();
      tx_push[ch] = 1'b0;
      drain_tx(ch);

      pndng[ch]    = 1'b1;
      data_out[ch] = vecs[v].data;
      wait_popin(ch);
      pndng[ch] = 1'b0;
      step();
      check("vec_rx_bcst", 64'(rx_bcst[ch]), 64'(vecs[v].exp_bcst));
      drain_rx(ch);
    end

    // ---- pop while empty is ignored; push+pop on empty keeps the push ----
    pop[0] = 1'b1;
    step();
    pop[0] = 1'b0;
    check("pop_empty_ignored", 64'(pndng_i_in[0]), 64'd0);
    tx_push[6] = 1'b1; pop[6] = 1'b1; tx_data[6] = 32'h00000066;
    tx_q[6].push_back(32'h00000066);
    step();
    tx_push[6] = 1'b0; pop[6] = 1'b0;
    check("push_pop_empty_drop", 64'(tx_drop_cnt[6]), 64'd0);
    drain_tx(6);

    // ---- ch3: five pushes into depth 4, one dropped ----
    tx_push[3] = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tx_data[3] = 32'h30000000 + 32'(i);
      if (i < 4) tx_q[3].push_back(32'h30000000 + 32'(i));
      step();
      if (i == 3) begin
        check("ch3_full_after_4", 64'(tx_full[3]), 64'd1);
        check("ch3_no_drop_yet", 64'(tx_drop_cnt[3]), 64'd0);
      end
    end
    tx_push[3] = 1'b0;
    check("ch3_drop_cnt", 64'(tx_drop_cnt[3]), 64'd1);
    drain_tx(3);
    check("ch3_not_full", 64'(tx_full[3]), 64'd0);

    // ---- ch1: full FIFO, simultaneous push and pop ----
    tx_push[1] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tx_data[1] = 32'h10000000 + 32'(i);
      tx_q[1].push_back(32'h10000000 + 32'(i));
      step();
    end
    check("ch1_full", 64'(tx_full[1]), 64'd1);
    tx_data[1] = 32'h00000005;
    pop[1] = 1'b1;
    exp = tx_q[1].pop_front();
    check("ch1_head_before_pp", 64'(data_out_i_in[1]), 64'(exp));
    tx_q[1].push_back(32'h00000005);
    step();
    tx_push[1] = 1'b0;
    pop[1] = 1'b0;
    check("ch1_still_full", 64'(tx_full[1]), 64'd1);
    check("ch1_no_drop", 64'(tx_drop_cnt[1]), 64'd0);
    drain_tx(1);

    // ---- ch7: held pndng, popin once every 3 cycles, broadcast flag ----
    pndng[7] = 1'b1;
    data_out[7] = 32'hFF00BEEF;
    rx_window(7, 12, pulses, bad);
    check("ch7_pulses", 64'(pulses), 64'd4);
    check("ch7_pulse_spacing", 64'(bad), 64'd0);
    pndng[7] = 1'b0;
    check("ch7_rx_bcst", 64'(rx_bcst[7]), 64'd1);
    drain_rx(7);

    // ---- ch2: unread RX, backpressure stops popin, one read frees one ----
    pndng[2] = 1'b1;
    data_out[2] = 32'h00C0FFEE;
    rx_window(2, 20, pulses, bad);
    check("ch2_pulses_until_full", 64'(pulses), 64'd4);
    check("ch2_rx_bcst", 64'(rx_bcst[2]), 64'd0);
    exp = rx_q[2].pop_front();
    check("ch2_head", 64'(rx_data[2]), 64'(exp));
    rx_pop[2] = 1'b1;
    step();
    rx_pop[2] = 1'b0;
    rx_window(2, 10, pulses, bad);
    check("ch2_one_more_pulse", 64'(pulses), 64'd1);
    pndng[2] = 1'b0;
    drain_rx(2);

    // ---- ch0: reset during POP with two RX entries buffered ----
    pndng[0] = 1'b1;
    data_out[0] = 32'h0000CAFE;
    rx_window(0, 7, pulses, bad);
    check("ch0_pulses_before_rst", 64'(pulses), 64'd3);
    check("ch0_in_pop", 64'(popin[0]), 64'd1);
    check("ch0_rx_has_data", 64'(rx_empty[0]), 64'd0);
    rx_q[0].delete();
    reset = 1'b0;
    #1;
    check("ch0_rst_popin", 64'(popin[0]), 64'd0);
    check("ch0_rst_rx_empty", 64'(rx_empty[0]), 64'd1);
    check("ch0_rst_rx_data", 64'(rx_data[0]), 64'd0);
    step();
    reset = 1'b1;
    step();
    check("ch0_resume_popin", 64'(popin[0]), 64'd1);
    if (popin[0]) rx_q[0].push_back(data_out[0]);
    pndng[0] = 1'b0;
    step();
    drain_rx(0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
